// File: rtl/ws2812_pkg.sv
// Shared WS2812 line definitions: FSM state encoding and default bit/frame timing in core clock cycles.
// Used by both the line decoder and the matching encoder so their timing always agrees.
package ws2812_pkg;

    localparam int WS_BIT_THRESH   = 30;
    localparam int WS_MAX_HIGH     = 60;
    localparam int WS_RESET_CYCLES = 2500;
    localparam int WS_PIX_W        = 24;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } ws_state_t;

endpackage

// File: rtl/line_synchronizer.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clk domain.
// Latency: 2 cycles; no flow control.
module line_synchronizer (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/ws2812_line_decoder.sv
// Decodes a WS2812 serial line into 24-bit GRB pixels with frame-gap and timing-error detection.
// Latency: 2 sync cycles + 1 cycle from the 24th falling edge to pix_valid; no backpressure (pulses are one-shot).
module ws2812_line_decoder
    import ws2812_pkg::*;
#(
    parameter int BIT_THRESH   = WS_BIT_THRESH,
    parameter int MAX_HIGH     = WS_MAX_HIGH,
    parameter int RESET_CYCLES = WS_RESET_CYCLES,
    parameter int IDX_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             line_in,
    output logic [23:0]      pix_data,
    output logic             pix_valid,
    output logic [IDX_W-1:0] pix_index,
    output logic             frame_done,
    output logic             err_timing,
    output logic             busy
);

    localparam int LO_W = $clog2(RESET_CYCLES + 1);
    localparam int HI_W = $clog2(MAX_HIGH + 2);

    localparam logic [LO_W-1:0] LO_END   = LO_W'(RESET_CYCLES);
    localparam logic [LO_W-1:0] LO_ONE   = LO_W'(1);
    localparam logic [HI_W-1:0] HI_SAT   = HI_W'(MAX_HIGH + 1);
    localparam logic [HI_W-1:0] HI_MAX   = HI_W'(MAX_HIGH);
    localparam logic [HI_W-1:0] HI_THR   = HI_W'(BIT_THRESH);
    localparam logic [HI_W-1:0] HI_ONE   = HI_W'(1);
    localparam logic [4:0]      LAST_BIT = 5'd23;

    logic             w_line;
    ws_state_t        r_state;
    ws_state_t        w_state_nxt;

    logic [LO_W-1:0]  r_lo_cnt;
    logic [LO_W-1:0]  w_lo_inc;
    logic             w_lo_end;
    logic [HI_W-1:0]  r_hi_cnt;
    logic [HI_W-1:0]  w_hi_inc;
    logic             w_hi_over;
    logic [4:0]       r_bit_cnt;
    logic [22:0]      r_shift;
    logic [IDX_W-1:0] r_idx;

    logic             w_bit_val;
    logic             w_shift_en;
    logic             w_word_done;
    logic             w_frame_end;
    logic             w_err;
    logic             w_valid;
    logic             w_busy;

    logic [23:0]      r_pix_data;
    logic             r_pix_valid;
    logic [IDX_W-1:0] r_pix_index;
    logic             r_frame_done;
    logic             r_err_timing;

    line_synchronizer u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (line_in),
        .o_sync  (w_line)
    );

    assign w_lo_inc  = r_lo_cnt + 1'b1;
    assign w_lo_end  = (w_lo_inc == LO_END);
    assign w_hi_inc  = (r_hi_cnt == HI_SAT) ? HI_SAT : r_hi_cnt + 1'b1;
    // Judge the count including the current high cycle so a MAX_HIGH+1 pulse errors before it ends.
    assign w_hi_over = (w_hi_inc > HI_MAX);
    assign w_bit_val = (r_hi_cnt > HI_THR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!ena) begin
            w_state_nxt = ST_SYNC;
        end else begin
            unique case (r_state)
                ST_SYNC: if (!w_line && w_lo_end) w_state_nxt = ST_IDLE;
                ST_IDLE: if (w_line) w_state_nxt = ST_HIGH;
                ST_HIGH: begin
                    if (w_line && w_hi_over) w_state_nxt = ST_SYNC;
                    else if (!w_line)        w_state_nxt = ST_LOW;
                end
                ST_LOW: begin
                    if (w_line)        w_state_nxt = ST_HIGH;
                    else if (w_lo_end) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_SYNC;
            endcase
        end
    end

    always_comb begin
        w_shift_en  = ena && (r_state == ST_HIGH) && !w_line;
        w_word_done = w_shift_en && (r_bit_cnt == LAST_BIT);
        w_frame_end = ena && (r_state == ST_LOW) && !w_line && w_lo_end;
        w_err       = ena && (((r_state == ST_HIGH) && w_line && w_hi_over) ||
                              (w_frame_end && (r_bit_cnt != 5'd0)));
        w_valid     = w_word_done && !w_err;
        w_busy      = (r_state == ST_HIGH) || (r_state == ST_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo_cnt     <= '0;
            r_hi_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_pix_data   <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_index  <= '0;
            r_frame_done <= 1'b0;
            r_err_timing <= 1'b0;
        end else if (!ena) begin
            r_lo_cnt     <= '0;
            r_hi_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_pix_index  <= '0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_timing <= 1'b0;
        end else begin
            r_pix_valid  <= w_valid;
            r_frame_done <= w_frame_end;
            r_err_timing <= w_err;
            if (w_valid) begin
                r_pix_data  <= {r_shift, w_bit_val};
                r_pix_index <= r_idx;
                r_idx       <= r_idx + 1'b1;
            end
            case (r_state)
                ST_SYNC: begin
                    r_lo_cnt  <= (w_line || w_lo_end) ? '0 : w_lo_inc;
                    r_hi_cnt  <= '0;
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                    r_idx     <= '0;
                end
                ST_IDLE: begin
                    r_lo_cnt <= '0;
                    if (w_line) begin
                        r_hi_cnt    <= HI_ONE;
                        r_idx       <= '0;
                        r_pix_index <= '0;
                    end
                end
                ST_HIGH: begin
                    if (w_line) begin
                        if (w_hi_over) begin
                            r_hi_cnt  <= '0;
                            r_bit_cnt <= '0;
                            r_shift   <= '0;
                        end else begin
                            r_hi_cnt <= w_hi_inc;
                        end
                    end else begin
                        r_lo_cnt <= LO_ONE;
                        r_hi_cnt <= '0;
                        if (w_word_done) begin
                            r_bit_cnt <= '0;
                            r_shift   <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= {r_shift[21:0], w_bit_val};
                        end
                    end
                end
                ST_LOW: begin
                    if (w_line) begin
                        r_hi_cnt <= HI_ONE;
                        r_lo_cnt <= '0;
                    end else if (w_lo_end) begin
                        r_lo_cnt    <= '0;
                        r_bit_cnt   <= '0;
                        r_shift     <= '0;
                        r_idx       <= '0;
                        r_pix_index <= '0;
                    end else begin
                        r_lo_cnt <= w_lo_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_data   = r_pix_data;
    assign pix_valid  = r_pix_valid;
    assign pix_index  = r_pix_index;
    assign frame_done = r_frame_done;
    assign err_timing = r_err_timing;
    assign busy       = w_busy;

endmodule

// File: tb/tb_ws2812_line_decoder.sv
// Directed bench for ws2812_line_decoder: frames, gaps, timing errors, threshold and index wrap.
module tb_ws2812_line_decoder;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        line_in;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic [1:0]  pix_index;
    logic        frame_done;
    logic        err_timing;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_frame = 0;
    int n_err   = 0;
    int n_both  = 0;
    logic [23:0] q_data[$];
    logic [1:0]  q_idx[$];

    ws2812_line_decoder #(
        .BIT_THRESH   (30),
        .MAX_HIGH     (60),
        .RESET_CYCLES (2500),
        .IDX_W        (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .line_in    (line_in),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .frame_done (frame_done),
        .err_timing (err_timing),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pix_valid) begin
            q_data.push_back(pix_data);
            q_idx.push_back(pix_index);
        end
        if (frame_done) n_frame++;
        if (err_timing) n_err++;
        if (frame_done && err_timing) n_both++;
    end

    function automatic logic [23:0] got_d(input int k);
        return (q_data.size() > k) ? q_data[k] : 24'hxxxxxx;
    endfunction

    function automatic logic [1:0] got_i(input int k);
        return (q_idx.size() > k) ? q_idx[k] : 2'bxx;
    endfunction

    task automatic drive(input logic v, input int n);
        line_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int nb,
                             input int h1, input int l1, input int h0, input int l0);
        for (int i = 23; i > 23 - nb; i--) begin
            drive(1'b1, w[i] ? h1 : h0);
            drive(1'b0, w[i] ? l1 : l0);
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        send_bits(w, 24, 40, 20, 20, 40);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; line_in = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if ({pix_valid, frame_done, err_timing, busy} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {pix_valid, frame_done, err_timing, busy}); else n_pass++;
        n_chk++; if (pix_data !== 24'h0) $display("FAIL reset_data: got %h want 000000", pix_data); else n_pass++;
        n_chk++; if (pix_index !== 2'd0) $display("FAIL reset_index: got %0d want 0", pix_index); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int bv; int bf; int be;
        drive(1'b0, 2510);
        bv = q_data.size(); bf = n_frame; be = n_err;
        send_word(24'h00FF00);
        n_chk++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        drive(1'b0, 2510);
        n_chk++; if (q_data.size() - bv !== 1) $display("FAIL single_cnt: got %0d want 1", q_data.size() - bv); else n_pass++;
        n_chk++; if (got_d(bv) !== 24'h00FF00) $display("FAIL single_data: got %h want 00ff00", got_d(bv)); else n_pass++;
        n_chk++; if (got_i(bv) !== 2'd0) $display("FAIL single_idx: got %0d want 0", got_i(bv)); else n_pass++;
        n_chk++; if (n_frame - bf !== 1) $display("FAIL single_frame: got %0d want 1", n_frame - bf); else n_pass++;
        n_chk++; if (n_err - be !== 0) $display("FAIL single_err: got %0d want 0", n_err - be); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_frame();
        int bv; int bf; int be;
        logic [23:0] exp_d [3];
        exp_d[0] = 24'h123456; exp_d[1] = 24'hABCDEF; exp_d[2] = 24'h000001;
        bv = q_data.size(); bf = n_frame; be = n_err;
        for (int p = 0; p < 3; p++) send_word(exp_d[p]);
        drive(1'b0, 2510);
        n_chk++; if (q_data.size() - bv !== 3) $display("FAIL frame_cnt: got %0d want 3", q_data.size() - bv); else n_pass++;
        for (int p = 0; p < 3; p++) begin
            n_chk++; if (got_d(bv + p) !== exp_d[p]) $display("FAIL frame_data%0d: got %h want %h", p, got_d(bv + p), exp_d[p]); else n_pass++;
            n_chk++; if (got_i(bv + p) !== 2'(p)) $display("FAIL frame_idx%0d: got %0d want %0d", p, got_i(bv + p), p); else n_pass++;
        end
        n_chk++; if (n_frame - bf !== 1) $display("FAIL frame_done_cnt: got %0d want 1", n_frame - bf); else n_pass++;
        n_chk++; if (n_err - be !== 0) $display("FAIL frame_err: got %0d want 0", n_err - be); else n_pass++;
    endtask

    task automatic test_partial();
        int bv; int bf; int be; int bb;
        bv = q_data.size(); bf = n_frame; be = n_err; bb = n_both;
        send_bits(24'hA5C000, 10, 40, 20, 20, 40);
        drive(1'b0, 2510);
        n_chk++; if (q_data.size() - bv !== 0) $display("FAIL partial_valid: got %0d want 0", q_data.size() - bv); else n_pass++;
        n_chk++; if (n_frame - bf !== 1) $display("FAIL partial_frame: got %0d want 1", n_frame - bf); else n_pass++;
        n_chk++; if (n_err - be !== 1) $display("FAIL partial_err: got %0d want 1", n_err - be); else n_pass++;
        n_chk++; if (n_both - bb !== 1) $display("FAIL partial_same_cycle: got %0d want 1", n_both - bb); else n_pass++;
        bv = q_data.size();
        send_word(24'h5AA55A);
        drive(1'b0, 2510);
        n_chk++; if (got_d(bv) !== 24'h5AA55A) $display("FAIL partial_next_data: got %h want 5aa55a", got_d(bv)); else n_pass++;
        n_chk++; if (got_i(bv) !== 2'd0) $display("FAIL partial_next_idx: got %0d want 0", got_i(bv)); else n_pass++;
    endtask

    task automatic test_long_pulse();
        int bv; int bf; int be;
        bv = q_data.size(); bf = n_frame; be = n_err;
        drive(1'b1, 61);
        drive(1'b0, 40);
        n_chk++; if (n_err - be !== 1) $display("FAIL long_err: got %0d want 1", n_err - be); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL long_busy: got %b want 0", busy); else n_pass++;
        send_word(24'hFFFFFF);
        drive(1'b0, 2510);
        n_chk++; if (q_data.size() - bv !== 0) $display("FAIL long_ignored: got %0d want 0", q_data.size() - bv); else n_pass++;
        n_chk++; if (n_frame - bf !== 0) $display("FAIL long_no_frame: got %0d want 0", n_frame - bf); else n_pass++;
        send_word(24'h0F0F0F);
        drive(1'b0, 2510);
        n_chk++; if (got_d(bv) !== 24'h0F0F0F) $display("FAIL long_resume: got %h want 0f0f0f", got_d(bv)); else n_pass++;
    endtask

    task automatic test_threshold();
        int bv; int be;
        bv = q_data.size(); be = n_err;
        send_bits(24'h5A3C96, 24, 31, 29, 30, 30);
        send_bits(24'hC3E187, 24, 60, 20, 1, 40);
        drive(1'b0, 2510);
        n_chk++; if (got_d(bv) !== 24'h5A3C96) $display("FAIL thresh_30_31: got %h want 5a3c96", got_d(bv)); else n_pass++;
        n_chk++; if (got_d(bv + 1) !== 24'hC3E187) $display("FAIL thresh_60_1: got %h want c3e187", got_d(bv + 1)); else n_pass++;
        n_chk++; if (n_err - be !== 0) $display("FAIL thresh_err: got %0d want 0", n_err - be); else n_pass++;
    endtask

    task automatic test_index_wrap();
        int bv;
        logic [1:0] exp_i [5];
        exp_i[0] = 2'd0; exp_i[1] = 2'd1; exp_i[2] = 2'd2; exp_i[3] = 2'd3; exp_i[4] = 2'd0;
        bv = q_data.size();
        for (int p = 0; p < 5; p++) send_word(24'h111111 * (p + 1));
        drive(1'b0, 2510);
        for (int p = 0; p < 5; p++) begin
            n_chk++; if (got_i(bv + p) !== exp_i[p]) $display("FAIL wrap_idx%0d: got %0d want %0d", p, got_i(bv + p), exp_i[p]); else n_pass++;
        end
        n_chk++; if (got_d(bv + 4) !== 24'h555555) $display("FAIL wrap_data: got %h want 555555", got_d(bv + 4)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bv;
        send_bits(24'hFFF000, 10, 40, 20, 20, 40);
        drive(1'b1, 10);
        rst_n = 1'b0;
        #1;
        n_chk++; if (pix_data !== 24'h0) $display("FAIL midrst_data: got %h want 000000", pix_data); else n_pass++;
        n_chk++; if ({pix_valid, frame_done, err_timing, busy} !== 4'b0) $display("FAIL midrst_flags: got %b want 0000", {pix_valid, frame_done, err_timing, busy}); else n_pass++;
        line_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bv = q_data.size();
        send_word(24'h777777);
        drive(1'b0, 100);
        n_chk++; if (q_data.size() - bv !== 0) $display("FAIL midrst_no_gap: got %0d want 0", q_data.size() - bv); else n_pass++;
        drive(1'b0, 2410);
        send_word(24'h246801);
        drive(1'b0, 2510);
        n_chk++; if (got_d(bv) !== 24'h246801) $display("FAIL midrst_after_gap: got %h want 246801", got_d(bv)); else n_pass++;
        n_chk++; if (got_i(bv) !== 2'd0) $display("FAIL midrst_idx: got %0d want 0", got_i(bv)); else n_pass++;
    endtask

    task automatic test_enable();
        int bv; int be; int bf;
        bv = q_data.size(); be = n_err; bf = n_frame;
        send_bits(24'hF80000, 5, 40, 20, 20, 40);
        line_in = 1'b1;
        ena = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL ena_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (pix_data !== 24'h246801) $display("FAIL ena_hold: got %h want 246801", pix_data); else n_pass++;
        ena = 1'b1;
        send_word(24'h999999);
        drive(1'b0, 100);
        n_chk++; if (q_data.size() - bv !== 0) $display("FAIL ena_resync: got %0d want 0", q_data.size() - bv); else n_pass++;
        n_chk++; if ((n_err - be) + (n_frame - bf) !== 0) $display("FAIL ena_pulses: got %0d want 0", (n_err - be) + (n_frame - bf)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_partial();
        test_long_pulse();
        test_threshold();
        test_index_wrap();
        test_reset_mid();
        test_enable();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/ws2812_line_decoder.md
WS2812_LINE_DECODER -- requirements
Module: ws2812_line_decoder

Interface
REQ-001 The block SHALL have parameter BIT_THRESH, default 30: high-pulse cycle count at or below which a bit decodes as 0.
REQ-002 The block SHALL have parameter MAX_HIGH, default 60: high-pulse cycle count above which the pulse is a timing error.
REQ-003 The block SHALL have parameter RESET_CYCLES, default 2500: low-time cycle count that marks a frame gap (50 us at 50 MHz).
REQ-004 The block SHALL have parameter IDX_W, default 8: width of the pixel index.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port ena, input, 1 bit: block enable; when low, the block is held in SYNC.
REQ-008 The block SHALL have port line_in, input, 1 bit: asynchronous WS2812 serial line, for example the LEDS_LINE driver output.
REQ-009 The block SHALL have port pix_data, output, 24 bits: the last decoded GRB word, G[23:16], R[15:8], B[7:0].
REQ-010 The block SHALL have port pix_valid, output, 1 bit: one-cycle pulse when pix_data is new.
REQ-011 The block SHALL have port pix_index, output, IDX_W bits: position in the frame of the pixel flagged by pix_valid.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse on frame-gap detection.
REQ-013 The block SHALL have port err_timing, output, 1 bit: one-cycle pulse on a timing violation.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a frame is in progress, i.e. in states HIGH or LOW.

Function
REQ-015 line_in SHALL pass through a 2-flop synchronizer; "line" below means the synchronized signal, with 2 cycles of latency.
REQ-016 The FSM SHALL have exactly four states: SYNC, IDLE, HIGH, LOW.
REQ-017 SYNC: a counter SHALL count consecutive low cycles; reaching RESET_CYCLES SHALL go to IDLE with no frame_done pulse; a high line SHALL clear the counter.
REQ-018 IDLE: a line rising edge SHALL go to HIGH with the high counter set to 1 and pix_index equal to 0.
REQ-019 HIGH: the high counter SHALL increment each cycle, saturating at MAX_HIGH+1.
REQ-020 HIGH, line still high and counter above MAX_HIGH: the block SHALL pulse err_timing, discard the partial word, and go to SYNC.
REQ-021 HIGH, on the falling edge: the decoded bit SHALL be (count > BIT_THRESH); it SHALL shift in MSB-first, and the FSM SHALL go to LOW with the low counter set to 1.
REQ-022 When the 24th bit shifts in: on the next cycle pix_data SHALL be updated, pix_valid SHALL pulse, and pix_index SHALL carry this pixel's position; the bit counter SHALL clear; pix_index SHALL then increment, wrapping modulo 2^IDX_W.
REQ-023 LOW, on a rising edge before RESET_CYCLES: the FSM SHALL go to HIGH; the next bit continues the word.
REQ-024 LOW, when the low counter reaches RESET_CYCLES: frame_done SHALL pulse once, pix_index SHALL clear to 0, and the FSM SHALL go to IDLE.
REQ-025 If the bit counter is non-zero at that point, err_timing SHALL pulse in the same cycle as frame_done and the partial bits SHALL be discarded.
REQ-026 A line held low indefinitely after frame_done SHALL produce no further pulses.
REQ-027 If a 24th-bit completion and an error fall in the same cycle, the error SHALL take priority and pix_valid SHALL stay low.
REQ-028 When ena is low: the FSM SHALL go to SYNC and all counters SHALL clear; pulses SHALL stay 0 and pix_data SHALL hold its value.
REQ-029 The low counter SHALL be ceil(log2(RESET_CYCLES+1)) bits wide, shared by SYNC and LOW.

Reset
REQ-030 When rst_n is low, the block SHALL immediately force state SYNC, clear all counters, the shift register and the synchronizer flops, and drive pix_data=0, pix_index=0, pix_valid=0, frame_done=0, err_timing=0, busy=0.
REQ-031 After rst_n deasserts, the block SHALL require a full RESET_CYCLES low gap before decoding, even if a reset occurred mid-frame.

Structure
REQ-032 A shared package ws2812_pkg SHALL hold the state enum and the default timing constants (BIT_THRESH, MAX_HIGH, RESET_CYCLES); the matching encoder SHALL reuse it.
REQ-033 The synchronizer SHALL be the sub-module line_synchronizer (2-flop, asynchronous active-low reset); everything else SHALL be in one FSM-and-datapath module.

Verification
REQ-034 Scenario: after reset, a 2500-cycle low gap then 24 bits of 0x00FF00 (bit 0 = 20H/40L, bit 1 = 40H/20L) -> one pix_valid with pix_data=0x00FF00 and pix_index=0.
REQ-035 Scenario: 3 pixels 0x123456, 0xABCDEF, 0x000001, then a 2500-cycle low -> pix_index 0,1,2, then one frame_done; no err_timing.
REQ-036 Scenario: 10 bits, then the line held low -> frame_done and err_timing in the same cycle; no pix_valid; the next frame decodes from index 0.
REQ-037 Scenario: a 61-cycle high pulse -> err_timing; the block is back in SYNC and ignores data until a 2500-cycle low.
REQ-038 Scenario: rst_n asserted mid-pixel, then deasserted, then a full frame -> all outputs 0 immediately; the first pixel is decoded only after the initial gap.
REQ-039 Scenario: high pulses of 30 and 31 cycles -> bits 0 and 1 respectively (threshold boundary); with IDX_W=2, 5 pixels -> pix_index 0,1,2,3,0.
